// File: rtl/regfile_test_pkg.sv
// Shared types and the pattern generator for the register-file write/verify
// sequencer. The pattern function is the single definition of what gets
// written, used both when writing and when regenerating expected read data.
package regfile_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_ADDR = 2'b01,
    MODE_WALK = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Test word for one address. The address is taken zero-extended to a byte,
  // which is exactly the byte replicated by the address pattern.
  function automatic logic [31:0] pattern(input mode_e      mode,
                                          input logic [7:0] addr,
                                          input logic [31:0] lfsr);
    logic [31:0] word;
    case (mode)
      MODE_ZERO: word = 32'h0;
      MODE_ADDR: word = {4{addr}};
      MODE_WALK: word = 32'h1 << addr;
      MODE_LFSR: word = lfsr;
      default:   word = 32'h0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 32-bit Galois LFSR. Reloaded with SEED at the start of each pass (write and
// verify) so both passes walk the identical sequence, one step per address.
module pattern_lfsr
  import regfile_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value
);

  // Load has priority so a pass boundary always restarts from the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/regfile_init_sequencer.sv
// Write-then-verify engine for a register file: writes a selectable pattern to
// every address, reads each one back and reports pass or the first failing
// address. Every output is a register; the FSM state runs one cycle ahead of
// the outputs it drives, and each read is compared one cycle after its
// address is presented.
module regfile_init_sequencer
  import regfile_test_pkg::*;
#(
  parameter int          ADDR_W = 5,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Mode,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] Err_Addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  mode_e             mode_q, mode_d;
  logic              issued_q, issued_d;  // every verify address presented
  logic              chk_q, chk_d;        // a read result is due this cycle
  logic [DATA_W-1:0] exp_q;               // expected data for R_Addr
  logic              lfsr_load, lfsr_adv, start_acc, mismatch;
  logic [31:0]       lfsr_value;
  logic [31:0]       pat;

  pattern_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  assign pat      = pattern(mode_q, 8'(cnt_q), lfsr_value);
  assign mismatch = (state_q == ST_VERIFY) && chk_q && (R_Data != exp_q);

  // FSM and address-counter state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_ZERO;
      issued_q <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      issued_q <= issued_d;
      chk_q    <= chk_d;
    end
  end

  // Next-state, counter and LFSR control.
  always_comb begin
    // NOTE: everything assigned here gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    issued_d  = issued_q;
    chk_d     = chk_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          start_acc = 1'b1;
          state_d   = ST_WRITE;
          cnt_d     = '0;
          mode_d    = mode_e'(Mode);
          lfsr_load = 1'b1;
          issued_d  = 1'b0;
          chk_d     = 1'b0;
        end
      end
      ST_WRITE: begin
        lfsr_adv = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d   = ST_VERIFY;
          cnt_d     = '0;
          lfsr_load = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_VERIFY: begin
        if (mismatch) begin
          state_d = ST_ERROR;
          chk_d   = 1'b0;
        end else if (issued_q) begin
          state_d = ST_DONE;
          chk_d   = 1'b0;
        end else begin
          chk_d    = 1'b1;
          lfsr_adv = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            issued_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, decoded from the current state and the decision
  // taken this cycle. Reset clears Write_Reg asynchronously.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      W_Addr    <= '0;
      W_Data    <= '0;
      Write_Reg <= 1'b0;
      R_Addr    <= '0;
      exp_q     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      Err_Addr  <= '0;
    end else begin
      Write_Reg <= (state_q == ST_WRITE);
      Busy      <= (state_q inside {ST_WRITE, ST_VERIFY}) &&
                   (state_d inside {ST_WRITE, ST_VERIFY});
      Done      <= (state_d inside {ST_DONE, ST_ERROR});
      Error     <= (state_d == ST_ERROR);
      if (state_q == ST_WRITE) begin
        W_Addr <= cnt_q;
        W_Data <= DATA_W'(pat);
      end
      if ((state_q == ST_VERIFY) && !mismatch && !issued_q) begin
        R_Addr <= cnt_q;
        // Address 0 is the hardwired zero register whatever was written.
        exp_q  <= (cnt_q == '0) ? '0 : DATA_W'(pat);
      end
      if (start_acc) begin
        Err_Addr <= '0;
      end else if (mismatch) begin
        Err_Addr <= R_Addr;
      end
    end
  end

endmodule

// File: tb/tb_regfile_init_sequencer.sv
// Scoreboard bench for regfile_init_sequencer: a register-file model with an
// optional stuck bit, expected writes and final results queued at Start, and
// a monitor that pops and compares as the DUT presents them.
module tb_regfile_init_sequencer;

  localparam int          ADDR_W = 5;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 32;
  localparam logic [31:0] SEED   = 32'h0000_0001;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic [1:0]        Mode = 2'b00;
  logic [ADDR_W-1:0] W_Addr, R_Addr, Err_Addr;
  logic [DATA_W-1:0] W_Data, R_Data;
  logic              Write_Reg, Busy, Done, Error;

  always #5 Clk = ~Clk;

  regfile_init_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .R_Addr(R_Addr), .R_Data(R_Data),
    .Busy(Busy), .Done(Done), .Error(Error), .Err_Addr(Err_Addr)
  );

  // Register file model: reg 0 always reads zero, optional stuck bit.
  logic [31:0] rf [DEPTH];
  bit          fault_en;
  int          fault_addr, fault_bit;
  bit          fault_val;

  always @(posedge Clk) if (Write_Reg) rf[W_Addr] <= W_Data;

  always_comb begin
    R_Data = (R_Addr == '0) ? 32'h0 : rf[R_Addr];
    if (fault_en && (int'(R_Addr) == fault_addr)) R_Data[fault_bit] = fault_val;
  end

  // Reference model.
  logic [31:0] lfsr_seq [DEPTH];

  function automatic logic [31:0] ref_word(int mode, int a);
    case (mode)
      1:       return 32'h0101_0101 * a;
      2:       return 32'h1 << a;
      3:       return lfsr_seq[a];
      default: return 32'h0;
    endcase
  endfunction

  typedef struct { int addr; logic [31:0] data; int edge_n; } wr_t;
  typedef struct { bit err; int err_addr; int edge_n; } res_t;
  wr_t wq[$];
  res_t rq[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, results_seen = 0, results_expected = 0;
  bit prev_done = 1'b0;

  always @(posedge Clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops expected writes and final results as the DUT presents them.
  always @(negedge Clk) begin
    wr_t w;
    res_t r;
    if (Reset) begin
      if (Write_Reg) begin
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d with nothing queued", W_Addr);
        end else begin
          w = wq.pop_front();
          check("w_addr", 32'(W_Addr), w.addr);
          check("w_data", W_Data, w.data);
          check("w_edge", cyc - start_cyc, w.edge_n);
          check("w_busy", 32'(Busy), 32'd1);
        end
      end
      if (Done && !prev_done) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: Error %0b Err_Addr %0d", Error, Err_Addr);
        end else begin
          r = rq.pop_front();
          check("res_error", 32'(Error), 32'(r.err));
          check("res_err_addr", 32'(Err_Addr), r.err_addr);
          check("res_edge", cyc - start_cyc, r.edge_n);
          check("res_busy", 32'(Busy), 32'd0);
        end
        results_seen++;
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Queue what this run must produce, then present Start for one edge.
  task automatic issue_run(int mode);
    res_t r;
    logic [31:0] expv, readv;
    for (int a = 0; a < DEPTH; a++) wq.push_back('{a, ref_word(mode, a), 1 + a});
    r = '{1'b0, 0, 1 + 2 * DEPTH};
    for (int k = 0; k < DEPTH; k++) begin
      expv  = (k == 0) ? 32'h0 : ref_word(mode, k);
      readv = expv;
      if (fault_en && k == fault_addr) readv[fault_bit] = fault_val;
      if (readv != expv) begin
        r = '{1'b1, k, DEPTH + 2 + k};
        break;
      end
    end
    rq.push_back(r);
    results_expected++;
    @(negedge Clk);
    Mode      = 2'(mode);
    Start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_result();
    int t = 0;
    while (results_seen < results_expected && t < 300) begin
      @(negedge Clk);
      t++;
    end
    check("done_within_budget", results_seen, results_expected);
    check("queue_drained", wq.size(), 0);
  endtask

  initial begin
    logic [31:0] s;
    int t;
    s = SEED;
    for (int i = 0; i < DEPTH; i++) begin
      lfsr_seq[i] = s;
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
    for (int i = 0; i < DEPTH; i++) rf[i] = 32'h0;
    fault_en = 1'b0; fault_addr = 0; fault_bit = 0; fault_val = 1'b0;

    // Reset state.
    repeat (3) @(negedge Clk);
    check("rst_w_addr", 32'(W_Addr), 0);
    check("rst_r_addr", 32'(R_Addr), 0);
    check("rst_w_data", W_Data, 0);
    check("rst_write_reg", 32'(Write_Reg), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_error", 32'(Error), 0);
    check("rst_err_addr", 32'(Err_Addr), 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Address-byte pattern.
    issue_run(1);
    wait_result();
    check("m01_reg5", rf[5], 32'h0505_0505);
    check("m01_done_hold", 32'(Done), 1);

    // Walking one.
    issue_run(2);
    wait_result();
    check("m10_reg31", rf[31], 32'h8000_0000);
    check("m10_reg1", rf[1], 32'h0000_0002);

    // LFSR, twice: both runs are held to the same reference sequence.
    issue_run(3);
    wait_result();
    issue_run(3);
    wait_result();

    // Bit 3 of reg 11 stuck at 0.
    fault_en = 1'b1; fault_addr = 11; fault_bit = 3; fault_val = 1'b0;
    issue_run(1);
    wait_result();
    repeat (5) @(negedge Clk);
    check("stuck_r_addr_held", 32'(R_Addr), 11);
    check("stuck_error", 32'(Error), 1);
    check("stuck_done", 32'(Done), 1);
    check("stuck_busy", 32'(Busy), 0);
    fault_en = 1'b0;

    // Start plus a Mode change during WRITE (sampled at edge 10) is ignored.
    issue_run(1);
    repeat (9) @(negedge Clk);
    Start = 1'b1;
    Mode  = 2'b10;
    @(negedge Clk);
    Start = 1'b0;
    wait_result();
    check("ignored_start_reg7", rf[7], 32'h0707_0707);

    // Reset while W_Addr = 7 during a walking-one run.
    issue_run(2);
    t = 0;
    while (!(Write_Reg && W_Addr == 5'd7) && t < 100) begin
      @(negedge Clk);
      t++;
    end
    check("saw_w_addr7", 32'(W_Addr), 7);
    Reset = 1'b0;
    #1;
    check("midrst_write_reg", 32'(Write_Reg), 0);
    check("midrst_busy", 32'(Busy), 0);
    wq.delete();
    rq.delete();
    results_seen = 0;
    results_expected = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_reg7_kept", rf[7], 32'h0707_0707);
    issue_run(1);
    wait_result();

    // Randomised runs with an optional stuck bit anywhere.
    for (int n = 0; n < 4; n++) begin
      fault_en   = 1'($urandom_range(0, 1));
      fault_addr = int'($urandom_range(1, DEPTH - 1));
      fault_bit  = int'($urandom_range(0, 31));
      fault_val  = 1'($urandom_range(0, 1));
      issue_run(int'($urandom_range(0, 3)));
      wait_result();
    end
    fault_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
